approx_mac_stream: RTL and testbench

- Parametrised, pipelined unsigned multiply-accumulate engine for the approximate-MAC datapath.
- Accepts an operand stream over a valid/ready handshake and computes a product per sample in one of three modes: exact, full OR-compressed approximate, or hybrid (approximate low columns, exact upper columns).
- Accumulates products per frame, delimited by `in_last`, and presents each frame result on a held output handshake with a sample count and a saturation flag.
- Replaces the change-detect accumulator with explicit framing, reset and backpressure.

---
 rtl/approx_mac_stream.sv | 150 +++++++++++++++
 tb/tb_approx_mac_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mac_stream.sv
// Pipelined unsigned MAC with exact / OR-approximate / hybrid products, framed accumulation.
module approx_mac_stream #(
  parameter int W         = 8,
  parameter int ACC_W     = 24,
  parameter int APPX_COLS = 8,
  parameter int CNT_W     = 8,
  parameter int SAT       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [1:0]         in_mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat
);

  localparam int          PW     = 2 * W;
  localparam int          EXT    = ACC_W + 1 - PW;
  localparam int unsigned WU     = W;
  localparam int unsigned PWU    = PW;
  localparam int unsigned APPX_U = APPX_COLS;
  localparam bit          SAT_EN = (SAT != 0);

  typedef enum logic [1:0] {
    MODE_EXACT  = 2'd0,
    MODE_OR     = 2'd1,
    MODE_HYBRID = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  logic [PW-1:0]    w_prod_ex;
  logic [PW-1:0]    w_prod_or;
  logic [PW-1:0]    w_mask;
  logic [PW-1:0]    w_prod_hy;
  logic [PW-1:0]    w_prod_sel;
  logic             w_stall;
  logic [ACC_W:0]   w_sum;
  logic             w_sat_now;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_sat_next;
  logic [CNT_W-1:0] w_cnt_next;

  logic             r_v1;
  logic [PW-1:0]    r_prod1;
  logic             r_last1;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_sat;

  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_cnt;
  assign out_sat   = r_out_sat;

  // Product generation: exact, carry-free AND/OR tree, and column-masked hybrid.
  always_comb begin
    w_prod_ex = PW'(in_a) * PW'(in_b);
    w_prod_or = '0;
    for (int unsigned j = 0; j < WU; j++) begin
      if (in_b[j]) w_prod_or = w_prod_or | (PW'(in_a) << j);
    end
    w_mask = '0;
    for (int unsigned k = 0; k < PWU; k++) begin
      w_mask[k] = (k < APPX_U);
    end
    w_prod_hy = (w_prod_ex & ~w_mask) | (w_prod_or & w_mask);
    case (mode_t'(in_mode))
      MODE_OR:     w_prod_sel = w_prod_or;
      MODE_HYBRID: w_prod_sel = w_prod_hy;
      default:     w_prod_sel = w_prod_ex;
    endcase
  end

  // Accumulate step: one extra sum bit detects overflow for saturation.
  always_comb begin
    w_sum      = {1'b0, r_acc} + {{EXT{1'b0}}, r_prod1};
    w_sat_now  = SAT_EN & w_sum[ACC_W];
    w_acc_next = w_sat_now ? '1 : w_sum[ACC_W-1:0];
    w_sat_next = r_sat | w_sat_now;
    w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  end

  // Stage 1: registered product and frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_prod1 <= '0;
      r_last1 <= 1'b0;
    end else if (clr) begin
      r_v1 <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_prod1 <= w_prod_sel;
        r_last1 <= in_last;
      end
    end
  end

  // Stage 2: frame accumulation and held result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_sat   <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      // A completing frame overrides the pop so back-to-back results keep out_valid high.
      if (!w_stall && r_v1) begin
        if (r_last1) begin
          r_out_valid <= 1'b1;
          r_out_acc   <= w_acc_next;
          r_out_cnt   <= w_cnt_next;
          r_out_sat   <= w_sat_next;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_sat       <= 1'b0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          r_sat <= w_sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mac_stream.sv
// Directed bench for approx_mac_stream: main 24-bit instance plus 16-bit saturating and wrapping copies.
module tb_approx_mac_stream;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_mode;
  logic        in_last;
  logic        out_ready;

  logic        o_ready, o_valid, o_sat;
  logic [23:0] o_acc;
  logic [7:0]  o_cnt;
  logic        s_ready, s_valid, s_sat;
  logic [15:0] s_acc;
  logic [7:0]  s_cnt;
  logic        w_ready, w_valid, w_sat;
  logic [15:0] w_acc;
  logic [7:0]  w_cnt;

  int errors = 0;
  int checks = 0;

  approx_mac_stream #(.W(8), .ACC_W(24), .APPX_COLS(4), .CNT_W(8), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(o_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(o_valid), .out_ready(out_ready), .out_acc(o_acc), .out_count(o_cnt), .out_sat(o_sat)
  );

  approx_mac_stream #(.W(8), .ACC_W(16), .APPX_COLS(4), .CNT_W(8), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(s_valid), .out_ready(out_ready), .out_acc(s_acc), .out_count(s_cnt), .out_sat(s_sat)
  );

  approx_mac_stream #(.W(8), .ACC_W(16), .APPX_COLS(4), .CNT_W(8), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(w_valid), .out_ready(out_ready), .out_acc(w_acc), .out_count(w_cnt), .out_sat(w_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input logic l);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_mode  = '0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clr = 1'b0; out_ready = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", o_valid); end
    checks++; if (o_acc !== 24'd0) begin errors++; $display("FAIL reset_acc: got %0d want 0", o_acc); end
    checks++; if (o_cnt !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_cnt); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0d want 0", o_sat); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0d want 1", o_ready); end
    tick();
  endtask

  task automatic test_modes();
    logic [7:0]  va [7];
    logic [7:0]  vb [7];
    logic [1:0]  vm [7];
    logic [23:0] ve [7];
    va = '{8'h0F, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 8'h05, 8'h0B};
    vb = '{8'h03, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h07, 8'h0B};
    vm = '{2'd0,  2'd1,  2'd2,  2'd1,  2'd2,  2'd3,  2'd2};
    ve = '{24'd45, 24'd31, 24'd47, 24'h7FFF, 24'hFE0F, 24'd35, 24'd127};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], vm[i], 1'b1);
      tick();
      idle();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_early_valid: got %0d want 0", i, o_valid); end
      tick();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %0d want 1", i, o_valid); end
      checks++; if (o_acc !== ve[i]) begin errors++; $display("FAIL mode%0d_acc: got %0h want %0h", i, o_acc, ve[i]); end
      checks++; if (o_cnt !== 8'd1) begin errors++; $display("FAIL mode%0d_count: got %0d want 1", i, o_cnt); end
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_pop: got %0d want 0", i, o_valid); end
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'h10, 8'h10, 2'd0, (i == 3));
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d: got %0d want 1", i, o_ready); end
      tick();
    end
    idle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %0d want 0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %0d want 1", o_valid); end
    checks++; if (o_acc !== 24'd1024) begin errors++; $display("FAIL stream_acc: got %0d want 1024", o_acc); end
    checks++; if (o_cnt !== 8'd4) begin errors++; $display("FAIL stream_count: got %0d want 4", o_cnt); end
    tick();
  endtask

  task automatic test_mixed();
    out_ready = 1'b1;
    drive(8'h0F, 8'h03, 2'd0, 1'b0); tick();
    drive(8'h0F, 8'h03, 2'd1, 1'b0); tick();
    drive(8'h0F, 8'h03, 2'd2, 1'b1); tick();
    idle();
    tick();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mixed_valid: got %0d want 1", o_valid); end
    checks++; if (o_acc !== 24'd123) begin errors++; $display("FAIL mixed_acc: got %0d want 123", o_acc); end
    checks++; if (o_cnt !== 8'd3) begin errors++; $display("FAIL mixed_count: got %0d want 3", o_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(8'd1, 8'd1, 2'd0, 1'b1);
    tick();
    drive(8'd2, 8'd2, 2'd0, 1'b1);
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd1) begin errors++; $display("FAIL b2b_first: got v=%0d acc=%0d want v=1 acc=1", o_valid, o_acc); end
    drive(8'd3, 8'd3, 2'd0, 1'b1);
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd4) begin errors++; $display("FAIL b2b_second: got v=%0d acc=%0d want v=1 acc=4", o_valid, o_acc); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0d want 1", o_ready); end
    idle();
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd9) begin errors++; $display("FAIL b2b_third: got v=%0d acc=%0d want v=1 acc=9", o_valid, o_acc); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", o_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    drive(8'hFF, 8'hFF, 2'd0, 1'b0); tick();
    drive(8'hFF, 8'hFF, 2'd0, 1'b1); tick();
    idle();
    tick();
    checks++; if (s_valid !== 1'b1 || s_acc !== 16'hFFFF) begin errors++; $display("FAIL sat_acc: got v=%0d acc=%0h want v=1 acc=ffff", s_valid, s_acc); end
    checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0d want 1", s_sat); end
    checks++; if (s_cnt !== 8'd2) begin errors++; $display("FAIL sat_count: got %0d want 2", s_cnt); end
    checks++; if (w_acc !== 16'hFC02) begin errors++; $display("FAIL wrap_acc: got %0h want fc02", w_acc); end
    checks++; if (w_sat !== 1'b0) begin errors++; $display("FAIL wrap_flag: got %0d want 0", w_sat); end
    checks++; if (o_acc !== 24'h01FC02 || o_sat !== 1'b0) begin errors++; $display("FAIL wide_acc: got acc=%0h sat=%0d want acc=1fc02 sat=0", o_acc, o_sat); end
    drive(8'd2, 8'd3, 2'd0, 1'b1);
    tick();
    idle();
    tick();
    checks++; if (s_acc !== 16'd6 || s_sat !== 1'b0) begin errors++; $display("FAIL sat_next_frame: got acc=%0d sat=%0d want acc=6 sat=0", s_acc, s_sat); end
    checks++; if (s_cnt !== 8'd1) begin errors++; $display("FAIL sat_next_count: got %0d want 1", s_cnt); end
    checks++; if (w_acc !== 16'd6) begin errors++; $display("FAIL wrap_next_frame: got %0d want 6", w_acc); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(8'd3, 8'd4, 2'd0, 1'b1);
    tick();
    idle();
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd12) begin errors++; $display("FAIL bp_frame1: got v=%0d acc=%0d want v=1 acc=12", o_valid, o_acc); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %0d want 0", o_ready); end
    drive(8'd5, 8'd5, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_ready: got %0d want 0", i, o_ready); end
      checks++; if (o_valid !== 1'b1 || o_acc !== 24'd12 || o_cnt !== 8'd1) begin errors++; $display("FAIL bp_hold%0d: got v=%0d acc=%0d cnt=%0d want v=1 acc=12 cnt=1", i, o_valid, o_acc, o_cnt); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0d want 1", o_ready); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_pop: got %0d want 0", o_valid); end
    drive(8'd6, 8'd6, 2'd0, 1'b1);
    tick();
    idle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_early: got %0d want 0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd61) begin errors++; $display("FAIL bp_frame2: got v=%0d acc=%0d want v=1 acc=61", o_valid, o_acc); end
    checks++; if (o_cnt !== 8'd2) begin errors++; $display("FAIL bp_frame2_count: got %0d want 2", o_cnt); end
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    drive(8'h10, 8'h10, 2'd0, 1'b0); tick();
    drive(8'h10, 8'h10, 2'd0, 1'b0); tick();
    clr = 1'b1;
    drive(8'hFF, 8'hFF, 2'd0, 1'b1);
    tick();
    clr = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0d want 0", o_valid); end
    checks++; if (o_acc !== 24'd61 || o_cnt !== 8'd2) begin errors++; $display("FAIL clr_keep: got acc=%0d cnt=%0d want acc=61 cnt=2", o_acc, o_cnt); end
    drive(8'd3, 8'd5, 2'd0, 1'b0);
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clr_after1: got %0d want 0", o_valid); end
    drive(8'd7, 8'd2, 2'd0, 1'b1);
    tick();
    idle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clr_after2: got %0d want 0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd29) begin errors++; $display("FAIL clr_result: got v=%0d acc=%0d want v=1 acc=29", o_valid, o_acc); end
    checks++; if (o_cnt !== 8'd2 || o_sat !== 1'b0) begin errors++; $display("FAIL clr_count: got cnt=%0d sat=%0d want cnt=2 sat=0", o_cnt, o_sat); end
    tick();
  endtask

  task automatic test_count_sat();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(8'd1, 8'd1, 2'd0, (i == 299));
      tick();
    end
    idle();
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd300) begin errors++; $display("FAIL cnt_acc: got v=%0d acc=%0d want v=1 acc=300", o_valid, o_acc); end
    checks++; if (o_cnt !== 8'd255) begin errors++; $display("FAIL cnt_sat: got %0d want 255", o_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(8'hFF, 8'hFF, 2'd0, 1'b0); tick();
    drive(8'hFF, 8'hFF, 2'd0, 1'b1); tick();
    idle();
    tick();
    checks++; if (s_valid !== 1'b1 || s_sat !== 1'b1) begin errors++; $display("FAIL rst_pre: got v=%0d sat=%0d want v=1 sat=1", s_valid, s_sat); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_acc !== 24'd0) begin errors++; $display("FAIL rst_mid_out: got v=%0d acc=%0d want v=0 acc=0", o_valid, o_acc); end
    checks++; if (o_cnt !== 8'd0 || o_sat !== 1'b0) begin errors++; $display("FAIL rst_mid_cnt: got cnt=%0d sat=%0d want 0 0", o_cnt, o_sat); end
    checks++; if (s_valid !== 1'b0 || s_sat !== 1'b0 || s_acc !== 16'd0) begin errors++; $display("FAIL rst_mid_sat: got v=%0d sat=%0d acc=%0d want 0 0 0", s_valid, s_sat, s_acc); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got ready=%0d v=%0d want 1 0", o_ready, o_valid); end
    out_ready = 1'b1;
    tick();
    drive(8'd2, 8'd3, 2'd0, 1'b1);
    tick();
    idle();
    tick();
    checks++; if (o_valid !== 1'b1 || o_acc !== 24'd6 || o_cnt !== 8'd1) begin errors++; $display("FAIL rst_post_frame: got v=%0d acc=%0d cnt=%0d want 1 6 1", o_valid, o_acc, o_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_streaming();
    test_mixed();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_clear();
    test_count_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
